// File: rtl/or16_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit OR-reduction among N_REQ requesters.
// One-entry registered result stage with valid/ready handshakes on both sides.
module or16_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [16*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_rsp_valid,
    output logic [IDW-1:0]        o_rsp_id,
    output logic                  o_rsp_or,
    input  logic                  i_rsp_ready
);

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [15:0]      r_word;

    logic             w_accept_en;
    logic [N_REQ-1:0] w_rot;
    logic             w_grant_vld;
    logic [IDW-1:0]   w_grant_id;
    logic             w_hs;
    logic [15:0]      w_word;
    logic [IDW-1:0]   w_ptr_nxt;

    function automatic logic or_16_way(input logic [15:0] word);
        return |word;
    endfunction

    // No acceptance while reset is asserted so nothing is granted on that edge.
    assign w_accept_en = ~i_reset & ((r_state == S_EMPTY) | i_rsp_ready);

    // Rotate so bit 0 is the requester at ptr; lowest rotated index wins.
    assign w_rot = N_REQ'({i_req_valid, i_req_valid} >> r_ptr);

    always_comb begin
        int sum;
        sum         = 0;
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                sum = int'(r_ptr) + i;
                if (sum >= N_REQ) sum = sum - N_REQ;
                w_grant_vld = 1'b1;
                w_grant_id  = IDW'(sum);
            end
        end
    end

    assign w_hs        = w_accept_en & w_grant_vld;
    assign o_req_ready = w_hs ? (N_REQ'(1) << w_grant_id) : '0;
    assign w_ptr_nxt   = (w_grant_id == IDW'(N_REQ - 1)) ? '0 : w_grant_id + IDW'(1);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_id == IDW'(i)) w_word = i_req_data[16*i +: 16];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_hs) w_state_nxt = S_FULL;
            S_FULL:  if (i_rsp_ready && !w_hs) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_ptr  <= w_ptr_nxt;
                r_id   <= w_grant_id;
                r_word <= w_word;
            end
        end
    end

    assign o_rsp_valid = (r_state == S_FULL);
    assign o_rsp_id    = r_id;
    assign o_rsp_or    = or_16_way(r_word);

endmodule

// File: tb/tb_or16_rr_arbiter.sv
// Directed bench for or16_rr_arbiter (N_REQ=4): grant order, backpressure,
// wrap-around, mid-operation reset and the OR-reduction result.
module tb_or16_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_or;
    logic        rsp_ready;

    int n_cmp = 0;
    int n_err = 0;

    or16_rr_arbiter #(.N_REQ(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_or    (rsp_or),
        .i_rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        rsp_ready = 1'b1;
        step();
        step();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_or !== 1'b0) begin n_err++; $display("FAIL reset_rsp_or got %b want 0", rsp_or); end
        req_valid = 4'b0000;
        req_data  = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_data  = '0;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want 0001", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_or !== 1'b0) begin n_err++; $display("FAIL single_or got %b want 0", rsp_or); end
        step();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [5];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) req_data[16*i +: 16] = 16'(1 << (4*i));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (req_ready !== (4'b0001 << exp_g[k])) begin n_err++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, 4'b0001 << exp_g[k]); end
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_g[k] || rsp_or !== 1'b1) begin
                n_err++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d or=%b want v=1 id=%0d or=1", k, rsp_valid, rsp_id, rsp_or, exp_g[k]);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_back_pressure();
        do_reset();
        req_data  = '0;
        req_data[47:32] = 16'h8000;
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant got %b want 0100", req_ready); end
        step();
        req_valid = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_or !== 1'b1 || req_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_hold[%0d] got v=%b id=%0d or=%b rdy=%b want v=1 id=2 or=1 rdy=0000", k, rsp_valid, rsp_id, rsp_or, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_refill_grant got %b want 1000", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_or !== 1'b0) begin
            n_err++; $display("FAIL bp_refill got v=%b id=%0d or=%b want v=1 id=3 or=0", rsp_valid, rsp_id, rsp_or);
        end
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        req_data  = '0;
        req_data[15:0]  = 16'h0001;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        step();
        req_valid = 4'b0101;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0 got %b want 0001", req_ready); end
        step();
        n_cmp++; if (rsp_id !== 2'd0 || rsp_or !== 1'b1) begin n_err++; $display("FAIL wrap_rsp0 got id=%0d or=%b want id=0 or=1", rsp_id, rsp_or); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL wrap_grant2 got %b want 0100", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (rsp_id !== 2'd2 || rsp_or !== 1'b0 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_rsp2 got v=%b id=%0d or=%b want v=1 id=2 or=0", rsp_valid, rsp_id, rsp_or);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data  = '0;
        req_data[31:16] = 16'h0040;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL mid_full got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id); end
        reset     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready got %b want 0000", req_ready); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_or !== 1'b0 || rsp_id !== 2'd0) begin
            n_err++; $display("FAIL mid_rst_state got v=%b id=%0d or=%b want v=0 id=0 or=0", rsp_valid, rsp_id, rsp_or);
        end
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr got %b want 0001", req_ready); end
        req_valid = 4'b0010;
        req_data[31:16] = 16'h0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_req1_grant got %b want 0010", req_ready); end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_or !== 1'b1) begin
            n_err++; $display("FAIL mid_req1_rsp got v=%b id=%0d or=%b want v=1 id=1 or=1", rsp_valid, rsp_id, rsp_or);
        end
        step();
    endtask

    task automatic test_sweep();
        logic [15:0] w;
        logic        exp_or;
        do_reset();
        req_data  = '0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k <= 16; k++) begin
            w      = (k < 16) ? 16'(1 << k) : 16'h0000;
            exp_or = (k < 16);
            req_data[15:0] = w;
            step();
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_or !== exp_or) begin
                n_err++; $display("FAIL sweep[%0d] data=%h got v=%b or=%b want v=1 or=%b", k, w, rsp_valid, rsp_or, exp_or);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
